// File: rtl/cordic_ln_pkg.sv
// Shared definitions for the CORDIC ln front end: sequencer state encoding and word sizing.
package cordic_ln_pkg;

    localparam int unsigned W_FLOAT     = 32;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStart = 3'd2,
        StWait  = 3'd3,
        StDone  = 3'd4,
        StAbort = 3'd5
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping at N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 3,
    localparam int unsigned PW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    gnt,
    output logic             valid
);

    // One spare bit so ptr + offset cannot overflow before the wrap.
    localparam int unsigned IW = PW + 1;

    logic [IW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        // Walk from the farthest offset down so the nearest set bit to ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'(ptr) + IW'(k);
            if (idx >= IW'(N_REQ)) begin
                idx = idx - IW'(N_REQ);
            end
            if (req[idx[PW-1:0]]) begin
                gnt   = idx[PW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_fixed_conv_arbiter.sv
// Round-robin sequencer sharing one float-to-fixed converter between N_REQ requesters,
// with a watchdog that resets a hung converter and reports the failed conversion.
module float_fixed_conv_arbiter
    import cordic_ln_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned W       = W_FLOAT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] float_in,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       result_out,
    output logic               err,
    output logic               busy,
    output logic [W-1:0]       conv_f,
    output logic               conv_begin,
    output logic               conv_rst,
    input  logic               conv_ack,
    input  logic [W-1:0]       conv_result
);

    localparam int unsigned   PW         = $clog2(N_REQ);
    localparam int unsigned   TW         = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] GNT_LAST   = PW'(N_REQ - 1);
    // The converter reset is held for two ABORT cycles; the timer counts them.
    localparam logic [TW-1:0] ABORT_LAST = TW'(1);

    state_e        state_q, state_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [W-1:0]  conv_f_q, conv_f_d;
    logic [W-1:0]  result_q, result_d;
    logic          err_q, err_d;
    logic          conv_rst_q;
    logic [PW-1:0] pick_gnt;
    logic          pick_valid;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        conv_f_d = conv_f_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d    = pick_gnt;
                    conv_f_d = float_in[32'(pick_gnt) * W +: W];
                    state_d  = StLoad;
                end
            end
            StLoad: state_d = StStart;
            StStart: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                // ACK on the last permitted cycle still completes normally.
                if (conv_ack) begin
                    result_d = conv_result;
                    err_d    = 1'b0;
                    state_d  = StDone;
                end else if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    state_d = StAbort;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StAbort: begin
                if (timer_q == ABORT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StDone: begin
                ptr_d   = (gnt_q == GNT_LAST) ? '0 : gnt_q + PW'(1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            ptr_q      <= '0;
            timer_q    <= '0;
            conv_f_q   <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            conv_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            timer_q    <= timer_d;
            conv_f_q   <= conv_f_d;
            result_q   <= result_d;
            err_q      <= err_d;
            conv_rst_q <= (state_d == StAbort);
        end
    end

    always_comb begin
        done = '0;
        if (state_q == StDone) begin
            done[gnt_q] = 1'b1;
        end
    end

    assign result_out = result_q;
    assign err        = err_q;
    assign busy       = (state_q != StIdle);
    assign conv_f     = conv_f_q;
    assign conv_begin = (state_q == StStart);
    assign conv_rst   = conv_rst_q;

endmodule

// File: tb/tb_float_fixed_conv_arbiter.sv
// Scoreboard bench for float_fixed_conv_arbiter with a behavioural converter and requesters.
module tb_float_fixed_conv_arbiter;

    localparam int unsigned N = 3;
    localparam int unsigned W = 32;

    localparam logic [31:0] FLT0 = 32'h3F80_0000;  // 1.0
    localparam logic [31:0] FLT1 = 32'h4000_0000;  // 2.0
    localparam logic [31:0] FLT2 = 32'h3F00_0000;  // 0.5
    localparam logic [31:0] FIX0 = 32'h0800_0000;
    localparam logic [31:0] FIX1 = 32'h1000_0000;
    localparam logic [31:0] FIX2 = 32'h0400_0000;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] float_in;
    logic [N-1:0]   done;
    logic [W-1:0]   result_out;
    logic           err;
    logic           busy;
    logic [W-1:0]   conv_f;
    logic           conv_begin;
    logic           conv_rst;
    logic           conv_ack;
    logic [W-1:0]   conv_result;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    int   rem[N];
    int   ack_delay = 10;
    int   cnt = -1;
    bit   stray_req = 1'b0;

    always #5 clk = ~clk;

    float_fixed_conv_arbiter #(
        .N_REQ   (N),
        .W       (W),
        .TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .float_in    (float_in),
        .done        (done),
        .result_out  (result_out),
        .err         (err),
        .busy        (busy),
        .conv_f      (conv_f),
        .conv_begin  (conv_begin),
        .conv_rst    (conv_rst),
        .conv_ack    (conv_ack),
        .conv_result (conv_result)
    );

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] conv_model(input logic [31:0] f);
        case (f)
            FLT0:    return FIX0;
            FLT1:    return FIX1;
            FLT2:    return FIX2;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit rem_pending();
        for (int i = 0; i < N; i++) if (rem[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Converter: ACK ack_delay cycles after BEGIN (never when negative), cleared by its reset.
    initial begin
        conv_ack    = 1'b0;
        conv_result = '0;
        forever begin
            @(posedge clk);
            #1;
            conv_ack = 1'b0;
            if (rst || conv_rst) cnt = -1;
            else if (conv_begin) cnt = ack_delay;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    conv_ack    = 1'b1;
                    conv_result = conv_model(conv_f);
                    cnt         = -1;
                end
            end
            if (stray_req) begin
                conv_ack    = 1'b1;
                conv_result = 32'h1234_5678;
                stray_req   = 1'b0;
            end
        end
    end

    // Requesters: hold REQ while work remains, drop it in the DONE cycle of the last grant.
    initial begin
        req = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (done[i] && rem[i] > 0) rem[i]--;
                req[i] = (rem[i] != 0);
            end
        end
    end

    // Monitor: every DONE pulse is matched against the head of the scoreboard.
    initial begin
        exp_t         x;
        logic [N-1:0] ed;
        forever begin
            @(negedge clk);
            if (done !== '0) begin
                check($onehot(done), "done_onehot", 32'(done), 32'(done));
                check(sb_q.size() != 0, "unexpected_done", 32'(done), 32'd0);
                if (sb_q.size() != 0) begin
                    x  = sb_q.pop_front();
                    ed = '0;
                    ed[x.idx] = 1'b1;
                    check(done === ed, "sb_grant", 32'(done), 32'(ed));
                    check(result_out === x.res, "sb_result", result_out, x.res);
                    check(err === x.err, "sb_err", 32'(err), 32'(x.err));
                end
            end
        end
    end

    task automatic push_exp(input int idx, input logic [31:0] res, input logic e);
        exp_t x;
        x.idx = idx;
        x.res = res;
        x.err = e;
        sb_q.push_back(x);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        #2;
        while ((busy || sb_q.size() != 0 || rem_pending()) && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        check(n < budget, "idle_within_budget", 32'(n), 32'(budget));
    endtask

    // One isolated request from an idle DUT, with begin latency, done latency and
    // converter-reset pulse length measured along the way.
    task automatic run_one(input int idx, input int delay, input logic [31:0] res,
                           input logic e, input int exp_lat, input int exp_rst);
        int n;
        int nrst;
        push_exp(idx, res, e);
        ack_delay = delay;
        rem[idx]  = 1;
        @(negedge clk);
        #2;
        n = 0;
        while (!conv_begin && n < 10) begin
            @(negedge clk);
            #2;
            n++;
        end
        check(n == 2, "begin_latency", 32'(n), 32'd2);
        n    = 0;
        nrst = 0;
        while (!done[idx] && n < 200) begin
            @(negedge clk);
            #2;
            n++;
            if (conv_rst) nrst++;
        end
        check(n == exp_lat, "done_latency", 32'(n), 32'(exp_lat));
        check(nrst == exp_rst, "conv_rst_cycles", 32'(nrst), 32'(exp_rst));
        wait_idle(20);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst      = 1'b0;
        float_in = {FLT2, FLT1, FLT0};
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check(done === '0, "rst_done", 32'(done), 32'd0);
        check(result_out === '0, "rst_result", result_out, 32'd0);
        check(err === 1'b0, "rst_err", 32'(err), 32'd0);
        check(busy === 1'b0, "rst_busy", 32'(busy), 32'd0);
        check(conv_f === '0, "rst_conv_f", conv_f, 32'd0);
        check(conv_begin === 1'b0, "rst_conv_begin", 32'(conv_begin), 32'd0);
        check(conv_rst === 1'b1, "rst_conv_rst", 32'(conv_rst), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check(conv_rst === 1'b0, "idle_conv_rst", 32'(conv_rst), 32'd0);

        // Stray ACK while idle must be ignored.
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check(busy === 1'b0, "stray_ack_busy", 32'(busy), 32'd0);
        check(result_out === '0, "stray_ack_result", result_out, 32'd0);

        // Contention from ptr=0: order 0,1,2,0.
        ack_delay = 3;
        push_exp(0, FIX0, 1'b0);
        push_exp(1, FIX1, 1'b0);
        push_exp(2, FIX2, 1'b0);
        push_exp(0, FIX0, 1'b0);
        rem[0] = 2;
        rem[1] = 1;
        rem[2] = 1;
        wait_idle(200);

        // Single request, ACK 10 cycles after BEGIN -> DONE 11 cycles after BEGIN.
        run_one(0, 10, FIX0, 1'b0, 11, 0);

        // Fairness wrap: serve 1 alone (ptr -> 2), then REQ=011 grants 0 then 1.
        run_one(1, 3, FIX1, 1'b0, 4, 0);
        ack_delay = 3;
        push_exp(0, FIX0, 1'b0);
        push_exp(1, FIX1, 1'b0);
        rem[0] = 1;
        rem[1] = 1;
        wait_idle(100);
        // ptr must have ended at 2: all three requesting now serve 2,0,1.
        push_exp(2, FIX2, 1'b0);
        push_exp(0, FIX0, 1'b0);
        push_exp(1, FIX1, 1'b0);
        rem[0] = 1;
        rem[1] = 1;
        rem[2] = 1;
        wait_idle(150);

        // Timeout: 64 WAIT cycles, 2 ABORT cycles, DONE 67 cycles after BEGIN.
        run_one(0, -1, 32'h0, 1'b1, 67, 2);
        run_one(1, 10, FIX1, 1'b0, 11, 0);
        // ACK on the final permitted cycle completes normally.
        run_one(2, 64, FIX2, 1'b0, 65, 0);

        // Async reset in WAIT: outputs return to reset values immediately, no DONE.
        ack_delay = 20;
        rem[0]    = 1;
        n = 0;
        while (!conv_begin && n < 10) begin
            @(negedge clk);
            #2;
            n++;
        end
        check(conv_begin === 1'b1, "t6_begin_seen", 32'(conv_begin), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        check(busy === 1'b1, "t6_busy_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check(busy === 1'b0, "t6_rst_busy", 32'(busy), 32'd0);
        check(conv_rst === 1'b1, "t6_rst_conv_rst", 32'(conv_rst), 32'd1);
        check(done === '0, "t6_rst_done", 32'(done), 32'd0);
        check(result_out === '0, "t6_rst_result", result_out, 32'd0);
        check(err === 1'b0, "t6_rst_err", 32'(err), 32'd0);
        check(conv_f === '0, "t6_rst_conv_f", conv_f, 32'd0);
        rem[0] = 0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check(busy === 1'b0, "t6_idle_after_release", 32'(busy), 32'd0);
        run_one(1, 5, FIX1, 1'b0, 6, 0);

        check(sb_q.size() == 0, "sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
